// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and requester indices for the regfile write-back arbiter.
// The helper below gives the wrap-around increment used by the round-robin pointer.
package rf_wb_arbiter_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: valid vector in, one-hot grant out.
// Search starts at the pointer; the pointer moves one past the winner only on a grant.
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx_s;
  logic          found_s;
  int            sum_s;

  // Scan from the pointer, wrapping modulo N, and grant the first valid requester.
  always_comb begin
    grant   = {N{1'b0}};
    ptr_d   = ptr_q;
    found_s = 1'b0;
    idx_s   = {PW{1'b0}};
    sum_s   = 0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr_q) + k;
      idx_s = PW'((sum_s >= N) ? (sum_s - N) : sum_s);
      if (!found_s && valid[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
        ptr_d        = PW'(wrap_inc(int'(idx_s), N));
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter with a per-register busy scoreboard.
// Busy bits clear on the edge where the registered write reaches the regfile.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              set_valid,
  input  logic [AW-1:0]     set_addr,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              dst_busy,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [2**AW-1:0]  busy_vec
);

  localparam int NR = 2**AW;

  logic [NREQ-1:0] grant_s;
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_data_s;

  logic            rf_we_q,    rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NR-1:0]   busy_q,     busy_d;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .valid (req_valid),
    .grant (grant_s)
  );

  assign req_ready = grant_s;

  // Winner's address/data; the grant is one-hot so OR-ing the slices is exact.
  always_comb begin
    win_addr_s = {AW{1'b0}};
    win_data_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        win_addr_s = win_addr_s | req_addr[i*AW +: AW];
        win_data_s = win_data_s | req_data[i*DW +: DW];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  // Write-port next state and scoreboard update (set overrides clear).
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    if (|grant_s) begin
      rf_we_d    = (win_addr_s != {AW{1'b0}});
      rf_waddr_d = win_addr_s;
      rf_wdata_d = win_data_s;
    end else begin
      rf_we_d = 1'b0;
    end
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (set_valid && (set_addr != {AW{1'b0}})) begin
      busy_d[set_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {AW{1'b0}};
      rf_wdata_q <= {DW{1'b0}};
      busy_q     <= {NR{1'b0}};
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy_vec = busy_q;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign dst_busy = busy_q[set_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus randomized bench for rf_wb_arbiter against a behavioural model
// (integer round-robin pointer, bit-array scoreboard, write-port state).
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              set_valid;
  logic [AW-1:0]     set_addr;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_busy, rs2_busy, dst_busy;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [NR-1:0]     busy_vec;

  int vectors     = 0;
  int miscompares = 0;

  int          m_ptr;
  bit          m_busy [NR];
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  int          m_last_grant;

  bit          pend [NREQ];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .set_valid (set_valid),
    .set_addr  (set_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .dst_busy  (dst_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_vec  (busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] busy_word();
    logic [NR-1:0] w;
    for (int r = 0; r < NR; r++) w[r] = m_busy[r];
    return w;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_we = 1'b0; m_waddr = 0; m_wdata = 32'h0; m_last_grant = -1;
    for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
  endtask

  task automatic put(input int i, input bit v, input int a, input logic [31:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = AW'(a);
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic check_comb();
    int g;
    logic [NREQ-1:0] exp_ready;
    g = pick(req_valid);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
    chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
    chk("dst_busy", dst_busy, m_busy[set_addr]);
  endtask

  task automatic edge_update();
    int g;
    bit nb [NR];
    g = pick(req_valid);
    nb = m_busy;
    if (m_we) nb[m_waddr] = 1'b0;
    if (set_valid && set_addr != 0) nb[set_addr] = 1'b1;
    if (g >= 0) begin
      m_waddr = int'(req_addr[g*AW +: AW]);
      m_wdata = req_data[g*DW +: DW];
      m_we    = (m_waddr != 0);
      m_ptr   = (g + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    m_busy = nb;
    m_last_grant = g;
  endtask

  task automatic check_regs();
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("busy_vec", busy_vec, busy_word());
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1 check_comb();
    @(posedge clk);
    edge_update();
    #1 check_regs();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_data = '0;
    set_valid = 1'b0; set_addr = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    m_reset();
    chk("rst_we", rf_we, 1'b0);
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_waddr", rf_waddr, 5'd0);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    m_reset();
    reset = 1'b1;
    #12;
    chk("init_we", rf_we, 1'b0);
    chk("init_wdata", rf_wdata, 32'h0);
    chk("init_busy", busy_vec, 32'h0);
    chk("init_ready", req_ready, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-cycle while a write is in flight and r4 is busy.
    set_valid = 1'b1; set_addr = 5'd4;
    put(1, 1'b1, 3, 32'hA5A5_0003);
    cycle();
    chk("t1_we", rf_we, 1'b1);
    chk("t1_busy", busy_vec, 32'h0000_0010);
    clear_inputs();
    mid_reset();

    // All three valid: grants rotate 0,1,2,0.
    put(0, 1'b1, 5, 32'h0000_0005);
    put(1, 1'b1, 6, 32'h0000_0006);
    put(2, 1'b1, 7, 32'h0000_0007);
    for (int k = 0; k < 4; k++) begin
      logic [NREQ-1:0] want;
      want = 3'b001 << (k % 3);
      #1 chk("t2_grant", req_ready, want);
      #1;
      cycle();
      chk("t2_waddr", rf_waddr, 5 + (k % 3));
    end
    clear_inputs();

    // Allocate r9, write it two cycles later, busy clears after the write commits.
    set_valid = 1'b1; set_addr = 5'd9; rs1_addr = 5'd9;
    cycle();
    set_valid = 1'b0;
    cycle();
    chk("t3_busy_a", rs1_busy, 1'b1);
    put(1, 1'b1, 9, 32'hDEAD_BEEF);
    #1 chk("t3_grant", req_ready, 3'b010);
    #1;
    cycle();
    chk("t3_we", rf_we, 1'b1);
    chk("t3_data", rf_wdata, 32'hDEAD_BEEF);
    put(1, 1'b0, 9, 32'hDEAD_BEEF);
    #1 chk("t3_busy_b", rs1_busy, 1'b1);
    #1;
    cycle();
    chk("t3_clr", busy_vec[9], 1'b0);
    chk("t3_we_off", rf_we, 1'b0);

    // Set and clear of r4 on the same edge: set wins.
    put(0, 1'b1, 4, 32'h0000_0044);
    cycle();
    chk("t4_wa", rf_waddr, 5'd4);
    put(0, 1'b0, 4, 32'h0000_0044);
    set_valid = 1'b1; set_addr = 5'd4;
    cycle();
    chk("t4_set_wins", busy_vec[4], 1'b1);
    set_valid = 1'b0;

    // Write to r0: handshake only, no regfile write.
    put(0, 1'b1, 0, 32'h0000_1234);
    #1 chk("t5_ready", req_ready, 3'b001);
    #1;
    cycle();
    chk("t5_we", rf_we, 1'b0);
    chk("t5_b0", busy_vec[0], 1'b0);
    put(0, 1'b0, 0, 32'h0);

    // Only req2 valid from ptr=0: granted every cycle and ptr wraps back to 0.
    mid_reset();
    put(2, 1'b1, 10, 32'h0000_00AA);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t6_grant", req_ready, 3'b100);
      #1;
      cycle();
    end
    put(0, 1'b1, 11, 32'h0000_00BB);
    put(1, 1'b1, 12, 32'h0000_00CC);
    #1 chk("t6_ptr0", req_ready, 3'b001);
    #1;
    clear_inputs();

    // Randomized traffic under the requester and issue contracts.
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int a;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          put(i, 1'b1, int'($urandom % 8), $urandom);
        end
      end
      a = int'($urandom % 8);
      if (!m_busy[a] && ($urandom % 3 == 0)) begin
        set_valid = 1'b1; set_addr = AW'(a);
      end else begin
        set_valid = 1'b0; set_addr = AW'($urandom % 32);
      end
      rs1_addr = AW'($urandom % 8);
      rs2_addr = AW'($urandom % 32);
      cycle();
      if (m_last_grant >= 0) begin
        pend[m_last_grant] = 1'b0;
        req_valid[m_last_grant] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
